// File: rtl/vga_line_fetch_pkg.sv
// rtl/vga_line_fetch_pkg.sv - shared constants for the VGA line-fetch stage
//
// Fetch FSM state encodings and the idle (deasserted) level of the
// active-low sync signals.
package vga_line_fetch_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REQ    = 1'b1;

    localparam logic       SYNC_IDLE = 1'b1;

endpackage

// File: rtl/vga_line_buffer.sv
// rtl/vga_line_buffer.sv - ping-pong line buffer, simple dual-port RAM
//
// Ports:
//   clk        system clock
//   wr_en_i    write enable
//   wr_addr_i  {bank, col} write address
//   wr_data_i  write data
//   rd_addr_i  {bank, col} read address
//   rd_data_o  registered read data (one clock after rd_addr_i)
module vga_line_buffer #(
    parameter int COL_W  = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [COL_W:0]    wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [COL_W:0]    rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [0:(2**(COL_W+1))-1];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/vga_line_fetch.sv
// rtl/vga_line_fetch.sv - prefetches framebuffer rows into a ping-pong line buffer and drives rgb
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   h_sync_in, v_sync_in active-low syncs from the timing stage
//   visible, h_pixel     active-area flag and current column from the timing stage
//   mem_req, mem_addr    framebuffer read request (held until mem_ack) and word address
//   mem_ack, mem_data    one-cycle acknowledge with read data
//   h_sync_out, v_sync_out  syncs delayed one clock to line up with rgb
//   rgb                  pixel colour, 0 outside the visible area
//   underrun             sticky flag: a row was not ready at its first visible cycle
module vga_line_fetch
    import vga_line_fetch_pkg::*;
#(
    parameter int LINE_PIXELS = 640,
    parameter int V_LINES     = 480,
    parameter int COLOR_BITS  = 8,
    parameter int ADDR_W      = 19,
    parameter int FB_BASE     = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           h_sync_in,
    input  logic                           v_sync_in,
    input  logic                           visible,
    input  logic [$clog2(LINE_PIXELS)-1:0] h_pixel,
    output logic                           mem_req,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic                           mem_ack,
    input  logic [COLOR_BITS-1:0]          mem_data,
    output logic                           h_sync_out,
    output logic                           v_sync_out,
    output logic [COLOR_BITS-1:0]          rgb,
    output logic                           underrun
);

    localparam int COL_W = $clog2(LINE_PIXELS);
    localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    // The previous-value registers double as the 1-clk sync delay flops.
    logic hs_q, vs_q, vis_q;

    logic [0:0]        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [ROW_W-1:0]  fetch_row_q, fetch_row_d;
    logic              front_q, front_d;
    logic              back_full_q, back_full_d;
    logic              restart_q, restart_d;
    logic              underrun_q, underrun_d;

    logic              frame_start, vis_rise, in_req, accept, last_col;
    logic              fill_done, back_ready, more_rows;
    logic [31:0]       next_row_num;
    logic [COLOR_BITS-1:0] rd_data;

    assign frame_start  = vs_q & ~v_sync_in;
    assign vis_rise     = visible & ~vis_q;
    assign in_req       = (state_q == ST_REQ);
    assign accept       = in_req & mem_ack;
    assign last_col     = (col_q == COL_W'(LINE_PIXELS - 1));
    // Completion is forwarded so a swap in the same cycle sees a full back buffer.
    assign fill_done    = accept & last_col & ~restart_q;
    assign back_ready   = back_full_q | fill_done;
    assign next_row_num = 32'(fetch_row_q) + 32'd1;
    assign more_rows    = next_row_num < 32'(V_LINES);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        addr_d      = addr_q;
        row_addr_d  = row_addr_q;
        fetch_row_d = fetch_row_q;
        front_d     = front_q;
        back_full_d = back_full_q;
        restart_d   = restart_q;
        underrun_d  = underrun_q;

        if (accept) begin
            if (restart_q) begin
                // Outstanding beat of an abandoned fetch: drop it and restart at row 0.
                restart_d = 1'b0;
                col_d     = '0;
                addr_d    = ADDR_W'(FB_BASE);
            end else if (last_col) begin
                back_full_d = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                col_d  = col_q + COL_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        if (frame_start) begin
            fetch_row_d = '0;
            row_addr_d  = ADDR_W'(FB_BASE);
            back_full_d = 1'b0;
            if (in_req && !accept) begin
                // mem_addr must hold until the pending ack arrives.
                restart_d = 1'b1;
            end else begin
                state_d   = ST_REQ;
                col_d     = '0;
                addr_d    = ADDR_W'(FB_BASE);
                restart_d = 1'b0;
            end
        end else if (vis_rise) begin
            if (back_ready) begin
                front_d     = ~front_q;
                back_full_d = 1'b0;
                if (more_rows) begin
                    fetch_row_d = fetch_row_q + ROW_W'(1);
                    row_addr_d  = row_addr_q + ADDR_W'(LINE_PIXELS);
                    state_d     = ST_REQ;
                    col_d       = '0;
                    addr_d      = row_addr_q + ADDR_W'(LINE_PIXELS);
                end
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q        <= SYNC_IDLE;
            vs_q        <= SYNC_IDLE;
            vis_q       <= 1'b0;
            state_q     <= ST_IDLE;
            col_q       <= '0;
            addr_q      <= '0;
            row_addr_q  <= ADDR_W'(FB_BASE);
            fetch_row_q <= '0;
            front_q     <= 1'b0;
            back_full_q <= 1'b0;
            restart_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hs_q        <= h_sync_in;
            vs_q        <= v_sync_in;
            vis_q       <= visible;
            state_q     <= state_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            row_addr_q  <= row_addr_d;
            fetch_row_q <= fetch_row_d;
            front_q     <= front_d;
            back_full_q <= back_full_d;
            restart_q   <= restart_d;
            underrun_q  <= underrun_d;
        end
    end

    // Read side uses the post-swap bank so pixel 0 of a new row comes from that row.
    vga_line_buffer #(
        .COL_W  (COL_W),
        .DATA_W (COLOR_BITS)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (accept & ~restart_q),
        .wr_addr_i ({~front_q, col_q}),
        .wr_data_i (mem_data),
        .rd_addr_i ({front_d, h_pixel}),
        .rd_data_o (rd_data)
    );

    assign mem_req    = in_req;
    assign mem_addr   = addr_q;
    assign h_sync_out = hs_q;
    assign v_sync_out = vs_q;
    // vis_q is visible delayed to match the registered RAM read.
    assign rgb        = vis_q ? rd_data : '0;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// tb/tb_vga_line_fetch.sv - directed self-checking bench for vga_line_fetch
module tb_vga_line_fetch;

    localparam int LP = 8;
    localparam int VL = 4;
    localparam int CB = 8;
    localparam int AW = 19;
    localparam int FB = 16;
    localparam int GAP = 45;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          h_sync_in = 1'b1;
    logic          v_sync_in = 1'b1;
    logic          visible = 1'b0;
    logic [2:0]    h_pixel = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [CB-1:0] mem_data = '0;
    logic          h_sync_out, v_sync_out;
    logic [CB-1:0] rgb;
    logic          underrun;

    int n_cmp = 0;
    int n_err = 0;

    logic          mem_stall = 1'b0;
    int            wait_cnt = 0;
    int            unstable = 0;
    logic          prev_req = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] acc_log[$];

    vga_line_fetch #(
        .LINE_PIXELS (LP),
        .V_LINES     (VL),
        .COLOR_BITS  (CB),
        .ADDR_W      (AW),
        .FB_BASE     (FB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .visible    (visible),
        .h_pixel    (h_pixel),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .rgb        (rgb),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Framebuffer model: data = addr[7:0], ack after two wait cycles.
    always @(negedge clk) begin
        if (reset) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            prev_req = 1'b0;
        end else begin
            if (mem_req && prev_req && !mem_ack && mem_addr !== prev_addr) unstable++;
            prev_req  = mem_req;
            prev_addr = mem_addr;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req && !mem_stall) begin
                if (wait_cnt >= 2) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_addr[7:0];
                    acc_log.push_back(mem_addr);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic frame_pulse();
        @(negedge clk);
        v_sync_in = 1'b0;
        repeat (2) @(negedge clk);
        v_sync_in = 1'b1;
    endtask

    task automatic show_row(input int base, input string nm);
        for (int p = 0; p <= LP; p++) begin
            @(negedge clk);
            if (p > 0) begin
                n_cmp++;
                if (rgb !== CB'(base + p - 1)) begin
                    n_err++;
                    $display("FAIL %s px%0d: rgb=%0d expected %0d", nm, p - 1, rgb, base + p - 1);
                end
            end
            if (p < LP) begin
                visible = 1'b1;
                h_pixel = 3'(p);
            end else begin
                visible = 1'b0;
                h_pixel = '0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        frame_pulse();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1) begin n_err++; $display("FAIL pre_reset_req: mem_req=%b expected 1", mem_req); end
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req_drop: mem_req=%b expected 0", mem_req); end
        @(negedge clk);
        n_cmp++;
        if (h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin
            n_err++; $display("FAIL reset_syncs: h=%b v=%b expected 1 1", h_sync_out, v_sync_out);
        end
        h_sync_in = 1'b1;
        v_sync_in = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rgb !== '0 || underrun !== 1'b0 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL reset_state: rgb=%0d underrun=%b req=%b expected 0 0 0", rgb, underrun, mem_req);
        end
    endtask

    task automatic test_first_row();
        acc_log.delete();
        frame_pulse();
        repeat (GAP) @(negedge clk);
        n_cmp++;
        if (acc_log.size() != LP) begin
            n_err++; $display("FAIL row0_req_count: got %0d expected %0d", acc_log.size(), LP);
        end else begin
            for (int i = 0; i < LP; i++) begin
                n_cmp++;
                if (acc_log[i] !== AW'(FB + i)) begin
                    n_err++; $display("FAIL row0_addr%0d: got %0d expected %0d", i, acc_log[i], FB + i);
                end
            end
        end
        n_cmp++;
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL row0_idle: mem_req=%b expected 0", mem_req); end
        show_row(FB, "row0");
        repeat (GAP) @(negedge clk);
    endtask

    task automatic test_full_frame();
        acc_log.delete();
        frame_pulse();
        repeat (GAP) @(negedge clk);
        for (int r = 0; r < VL; r++) begin
            show_row(FB + LP * r, $sformatf("frame_row%0d", r));
            repeat (GAP) @(negedge clk);
        end
        n_cmp++;
        if (acc_log.size() != LP * VL) begin
            n_err++; $display("FAIL frame_req_count: got %0d expected %0d", acc_log.size(), LP * VL);
        end
        n_cmp++;
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL frame_no_5th: mem_req=%b expected 0", mem_req); end
        n_cmp++;
        if (underrun !== 1'b0) begin n_err++; $display("FAIL frame_underrun: underrun=%b expected 0", underrun); end
    endtask

    task automatic test_restart();
        int t;
        frame_pulse();
        repeat (GAP) @(negedge clk);
        show_row(FB, "rs_row0");
        repeat (GAP) @(negedge clk);
        show_row(FB + LP, "rs_row1");
        acc_log.delete();
        frame_pulse();
        t = 0;
        while (acc_log.size() < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (acc_log.size() < 2) begin
            n_err++; $display("FAIL restart_timeout: accepted %0d expected 2", acc_log.size());
        end else begin
            n_cmp++;
            if (acc_log[0] < AW'(FB + 2 * LP) || acc_log[0] > AW'(FB + 3 * LP - 1)) begin
                n_err++; $display("FAIL restart_pending: addr=%0d expected row2 range %0d..%0d", acc_log[0], FB + 2 * LP, FB + 3 * LP - 1);
            end
            n_cmp++;
            if (acc_log[1] !== AW'(FB)) begin
                n_err++; $display("FAIL restart_addr: addr=%0d expected %0d", acc_log[1], FB);
            end
        end
        repeat (GAP) @(negedge clk);
        show_row(FB, "rs_new_row0");
    endtask

    task automatic test_sync_delay();
        @(negedge clk);
        visible = 1'b0;
        h_pixel = '0;
        @(negedge clk);
        n_cmp++;
        if (rgb !== '0) begin n_err++; $display("FAIL rgb_invisible: rgb=%0d expected 0", rgb); end
        h_sync_in = 1'b0;
        #1;
        n_cmp++;
        if (h_sync_out !== 1'b1) begin n_err++; $display("FAIL hs_same_cycle: h_sync_out=%b expected 1", h_sync_out); end
        @(negedge clk);
        n_cmp++;
        if (h_sync_out !== 1'b0) begin n_err++; $display("FAIL hs_delay: h_sync_out=%b expected 0", h_sync_out); end
        h_sync_in = 1'b1;
        v_sync_in = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (h_sync_out !== 1'b1 || v_sync_out !== 1'b0) begin
            n_err++; $display("FAIL sync_delay: h=%b v=%b expected 1 0", h_sync_out, v_sync_out);
        end
        v_sync_in = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (v_sync_out !== 1'b1) begin n_err++; $display("FAIL vs_release: v_sync_out=%b expected 1", v_sync_out); end
        repeat (GAP) @(negedge clk);
    endtask

    task automatic test_underrun();
        frame_pulse();
        repeat (GAP) @(negedge clk);
        show_row(FB, "ur_row0");
        mem_stall = 1'b1;
        n_cmp++;
        if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_before: underrun=%b expected 0", underrun); end
        repeat (GAP) @(negedge clk);
        show_row(FB, "ur_repeat");
        n_cmp++;
        if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_set: underrun=%b expected 1", underrun); end
        mem_stall = 1'b0;
        repeat (GAP) @(negedge clk);
        frame_pulse();
        repeat (GAP) @(negedge clk);
        show_row(FB, "ur_next_frame");
        n_cmp++;
        if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_sticky: underrun=%b expected 1", underrun); end
        n_cmp++;
        if (unstable != 0) begin n_err++; $display("FAIL handshake_stable: changes=%0d expected 0", unstable); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_reset_clear: underrun=%b expected 0", underrun); end
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_full_frame();
        test_restart();
        test_sync_delay();
        test_underrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
